inst_rom: RTL and testbench
===========================

# inst_rom

Instruction memory responder on the fetch side of the core. It answers the `pc`/`ce` fetch requests issued by the PC register and returns one 32-bit instruction word per accepted request. A loader write port fills the array before or between runs. An optional wait-state engine models slow memory and reports `busy` to the stall logic.

## Interface

Parameters:
- `ADDR_W`, default 10: word-index width; the array holds 2^ADDR_W words.
- `WAIT_CYCLES`, default 2: extra response latency in cycles. It is used only with `INST_ROM_WAIT_EN`. Legal range is 0..15.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset (`RstEnable`).
- `ce`  in  1: fetch request / chip enable (`ChipEnable`=1).
- `addr`  in  `InstAddrBus` (32): byte address of the fetch.
- `inst`  out  `InstBus` (32): returned instruction word.
- `inst_valid`  out  1: `inst` holds a response this cycle.
- `addr_err`  out  1: the response belongs to a misaligned or out-of-range address. Qualified by `inst_valid`.
- `busy`  out  1: a request is in flight and new requests are ignored. Always 0 without `INST_ROM_WAIT_EN`.
- `wr_en`  in  1: loader write strobe.
- `wr_addr`  in  `ADDR_W`: loader word index.
- `wr_data`  in  32: loader data.

## Operation

- Reset values: `inst`=0, `inst_valid`=0, `addr_err`=0, `busy`=0, state IDLE, wait counter 0. Array contents are not reset.
- Word index = `addr[ADDR_W+1:2]`.
- Misaligned access: `addr[1:0]`≠0.
- Out-of-range access: `addr[31:ADDR_W+2]`≠0.
- Either error returns `inst`=0 (NOP) with `addr_err`=1. The array is not read.
- Writes: when `wr_en`=1 at a rising edge, `mem[wr_addr]` ← `wr_data`. Writes are independent of fetch state.
- Read/write collision on the same word in the same cycle: read-first; the fetch returns the old word.
- A request is accepted when `ce`=1 and `busy`=0 at a rising edge. `addr` is captured at acceptance.
- When there is no response, `inst` is driven 0 and `inst_valid`=0. `inst` never holds stale data.
- State machine (with `INST_ROM_WAIT_EN`):
  - IDLE: an accepted request with `WAIT_CYCLES`=0 goes to RESP. An accepted request with `WAIT_CYCLES`>0 goes to WAIT and loads the counter with `WAIT_CYCLES`-1.
  - WAIT: `busy`=1. The counter decrements each cycle and moves to RESP at 0. If `ce` is 0 at any edge, the request aborts to IDLE with no response.
  - RESP: `inst_valid`=1 for exactly one cycle and `busy`=0. A new request accepted in this cycle restarts the sequence (back-to-back); otherwise the block returns to IDLE.
- `rst` at any time, including mid-WAIT, forces IDLE and the reset values on the next edge. A pending request is dropped.

## Timing

- Without macro: fully pipelined. A request accepted at edge N produces `inst`/`inst_valid`/`addr_err` registered at edge N+1, i.e. 1-cycle latency. One response per cycle while `ce`=1.
- With macro: latency = 1 + `WAIT_CYCLES` edges from acceptance to `inst_valid`.
- `busy` rises on the edge after acceptance (when `WAIT_CYCLES`>0) and falls on the edge that enters RESP.
- Throughput with macro: one word per 1 + `WAIT_CYCLES` cycles.
- `ce` low at edge N: `inst_valid`=0 and `inst`=0 after edge N+1.

## Configuration

- `INST_ROM_WAIT_EN` defined: the IDLE/WAIT/RESP state machine, wait counter and `busy` are compiled in, with latency 1 + `WAIT_CYCLES`.
- Undefined: there is no state machine or counter, and `WAIT_CYCLES` is ignored. The block is a 1-cycle registered read, and `busy` is tied to 0.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `ce`=1 → `inst`=0, `inst_valid`=0, `busy`=0, `addr_err`=0 throughout.
- Load and stream (no macro): write words 0..3 = 0x11111111..0x44444444, then drive `addr`=0,4,8,12 on consecutive cycles → `inst` = 0x11111111..0x44444444 on the next four cycles with `inst_valid`=1 each cycle.
- Errors: fetch `addr`=0x2 → `inst`=0 and `addr_err`=1. Fetch `addr`=0x00001000 with `ADDR_W`=10 → `inst`=0 and `addr_err`=1.
- Collision: write `mem[5]`=0xDEADBEEF while fetching `addr`=0x14 (old value 0x0) → returns 0x0. The next fetch of `addr`=0x14 returns 0xDEADBEEF.
- Wait states (macro, `WAIT_CYCLES`=2): accept at edge 0 → `busy`=1 after edges 1–2, `inst_valid`=1 after edge 3. A request held during `busy` is ignored. A back-to-back request in RESP gives its next valid at edge 6.
- Abort and reset: with the macro on, drop `ce` mid-WAIT → no `inst_valid` and return to IDLE. In a separate run, assert `rst` mid-WAIT → `busy`=0 and no response.

Source files
------------

// File: rtl/inst_rom.sv
// inst_rom: instruction fetch memory with loader write port; registered 1-cycle read.
// Define INST_ROM_WAIT_EN to add the IDLE/WAIT/RESP wait-state engine and busy.
module inst_rom #(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              addr_err,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] inst_q, inst_d, rd_addr, rd_word;
  logic inst_valid_q, inst_valid_d, addr_err_q, addr_err_d, rd_err;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // Reads are combinational off the array, so a same-edge write is seen only by later fetches.
  assign rd_err = |rd_addr[1:0] || |(rd_addr >> (ADDR_W + 2));
  assign rd_word = rd_err ? 32'h0 : mem[rd_addr[ADDR_W+1:2]];
`ifdef INST_ROM_WAIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  assign busy = state_q == WAIT;
  assign rd_addr = busy ? addr_q : addr;
  always_comb begin
    state_d = IDLE;
    cnt_d = cnt_q;
    addr_d = addr_q;
    if (busy) begin
      state_d = !ce ? IDLE : cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d = cnt_q - 4'd1;
    end else if (ce) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d = 4'(WAIT_CYCLES - 1);
      addr_d = addr;
    end
    inst_valid_d = state_d == RESP;
    addr_err_d = inst_valid_d && rd_err;
    inst_d = inst_valid_d ? rd_word : 32'h0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
`else
  assign busy = 1'b0;
  assign rd_addr = addr;
  always_comb begin
    inst_valid_d = ce;
    addr_err_d = ce && rd_err;
    inst_d = ce ? rd_word : 32'h0;
  end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      inst_q <= 32'h0;
      inst_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q <= addr_err_d;
    end
  assign inst = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: randomized self-checking bench for inst_rom against an array-based reference.
module tb_inst_rom;
  localparam int AW = 10;
  localparam int W = 2;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst, ce, wr_en, inst_valid, addr_err, busy;
  logic [31:0] addr, inst, wr_data;
  logic [AW-1:0] wr_addr;
  logic [31:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;
  inst_rom #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst), .inst_valid(inst_valid),
    .addr_err(addr_err), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH);
  endfunction
  function automatic logic [31:0] word(input logic [31:0] a);
    return bad(a) ? 32'h0 : ref_mem[a / 4];
  endfunction
  task automatic step(input logic c, input logic [31:0] a, input logic we,
                      input logic [AW-1:0] wa, input logic [31:0] wd, input string tag);
    logic [31:0] e_inst;
    logic e_err;
    ce = c; addr = a; wr_en = we; wr_addr = wa; wr_data = wd;
    e_err = c && bad(a);
    e_inst = c ? word(a) : 32'h0;
    @(posedge clk); #1;
    if (we) ref_mem[wa] = wd;
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".valid"}, inst_valid, c);
    chk({tag, ".err"}, addr_err, e_err);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask
`ifdef INST_ROM_WAIT_EN
  task automatic fetch(input logic [31:0] a, input string tag);
    logic [31:0] e_inst;
    logic e_err;
    ce = 1'b1; addr = a; wr_en = 1'b0;
    e_inst = word(a);
    e_err = bad(a);
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".wvalid"}, inst_valid, 1'b0);
      chk({tag, ".winst"}, inst, 32'h0);
      addr = $urandom;
    end
    @(posedge clk); #1;
    chk({tag, ".valid"}, inst_valid, 1'b1);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".err"}, addr_err, e_err);
    chk({tag, ".rbusy"}, busy, 1'b0);
  endtask
`endif
  initial begin
    logic [31:0] a, d;
    logic [AW-1:0] wa;
    rst = 1'b1; ce = 1'b1; addr = 32'h0; wr_en = 1'b0; wr_addr = '0; wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      addr = $urandom & 32'hffc;
      @(posedge clk); #1;
      chk("rst.inst", inst, 32'h0);
      chk("rst.valid", inst_valid, 1'b0);
      chk("rst.err", addr_err, 1'b0);
      chk("rst.busy", busy, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = i < 4 ? 32'h11111111 * (i + 1) : i == 5 ? 32'h0 : $urandom;
      wa = AW'(i);
      step(1'b0, 32'h0, 1'b1, wa, d, "fill");
    end
`ifndef INST_ROM_WAIT_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, '0, 32'h0, "stream");
      chk("stream.const", inst, 32'h11111111 * (i + 1));
    end
    step(1'b1, 32'h2, 1'b0, '0, 32'h0, "misalign");
    step(1'b1, 32'h1000, 1'b0, '0, 32'h0, "oor");
    step(1'b1, 32'h14, 1'b1, 10'd5, 32'hDEADBEEF, "coll_old");
    chk("coll_old.const", inst, 32'h0);
    step(1'b1, 32'h14, 1'b0, '0, 32'h0, "coll_new");
    chk("coll_new.const", inst, 32'hDEADBEEF);
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 8)
        0: a = ($urandom % (4 * DEPTH)) | 32'h1;
        1: a = $urandom | 32'h0001_0000;
        default: a = ($urandom % DEPTH) * 4;
      endcase
      wa = ($urandom % 3 == 0) ? a[AW+1:2] : AW'($urandom);
      step(($urandom % 4) != 0, a, 1'($urandom), wa, $urandom, "rand");
    end
    step(1'b0, 32'h4, 1'b0, '0, 32'h0, "ce_low");
`else
    fetch(32'h0, "wait0");
    chk("wait0.const", inst, 32'h11111111);
    fetch(32'h4, "b2b");
    chk("b2b.const", inst, 32'h22222222);
    for (int i = 0; i < 30; i++) begin
      case ($urandom % 6)
        0: a = ($urandom % (4 * DEPTH)) | 32'h2;
        1: a = $urandom | 32'h0010_0000;
        default: a = ($urandom % DEPTH) * 4;
      endcase
      fetch(a, "wrand");
    end
    step(1'b0, 32'h0, 1'b0, '0, 32'h0, "idle");
    ce = 1'b1; addr = 32'h8;
    @(posedge clk); #1;
    chk("abort.busy", busy, 1'b1);
    ce = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("abort.valid", inst_valid, 1'b0);
      chk("abort.busy0", busy, 1'b0);
      chk("abort.inst", inst, 32'h0);
    end
    ce = 1'b1; addr = 32'hc;
    @(posedge clk); #1;
    chk("rstw.busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw.busy0", busy, 1'b0);
    chk("rstw.valid", inst_valid, 1'b0);
    rst = 1'b0; ce = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("rstw.novalid", inst_valid, 1'b0);
      chk("rstw.nobusy", busy, 1'b0);
    end
    fetch(32'h14, "after");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
